// File: rtl/trap_unit_if.sv
// Bundle of the trap controller's exception/CSR/PC-select signals.
// The master side is the pipeline and CSR file; the slave side is trap_unit.
interface trap_unit_if #(
    parameter int XLEN    = 64,
    parameter int NUM_IRQ = 16,
    parameter int CAUSE_W = 6
);
    logic               exc_en;
    logic [CAUSE_W-1:0] exc_code;
    logic [XLEN-1:0]    exc_val;
    logic [NUM_IRQ-1:0] irq_pending;
    logic [NUM_IRQ-1:0] irq_enable;
    logic               mret;
    logic [XLEN-1:0]    pc_addr;
    logic [XLEN-1:0]    mtvec;
    logic [XLEN-1:0]    mepc_current;
    logic [1:0]         priv_lvl;
    logic [XLEN-1:0]    mstatus_current;
    logic               flush_ack;

    logic               busy;
    logic               trap_taken;
    logic [XLEN-1:0]    pc_trap_next;
    logic               pc_ret_taken;
    logic [XLEN-1:0]    pc_ret;
    logic               csr_we;
    logic [XLEN-1:0]    mepc_next;
    logic [XLEN-1:0]    mcause_next;
    logic [XLEN-1:0]    mtval_next;
    logic [XLEN-1:0]    mstatus_next;
    logic [1:0]         priv_lvl_next;

    modport master (
        output exc_en, exc_code, exc_val, irq_pending, irq_enable, mret,
               pc_addr, mtvec, mepc_current, priv_lvl, mstatus_current, flush_ack,
        input  busy, trap_taken, pc_trap_next, pc_ret_taken, pc_ret, csr_we,
               mepc_next, mcause_next, mtval_next, mstatus_next, priv_lvl_next
    );

    modport slave (
        input  exc_en, exc_code, exc_val, irq_pending, irq_enable, mret,
               pc_addr, mtvec, mepc_current, priv_lvl, mstatus_current, flush_ack,
        output busy, trap_taken, pc_trap_next, pc_ret_taken, pc_ret, csr_we,
               mepc_next, mcause_next, mtval_next, mstatus_next, priv_lvl_next
    );
endinterface

// File: rtl/trap_unit.sv
// Trap controller: arbitrates exception vs. interrupts vs. mret, waits for the
// pipeline drain acknowledge, then commits the CSR updates and PC redirect.
module trap_unit #(
    parameter int XLEN        = 64,
    parameter int NUM_IRQ     = 16,
    parameter int CAUSE_W     = 6,
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic      clk,
    input  logic      rst_n,
    trap_unit_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;

    state_t             state_q, state_d;
    logic               is_irq_q, is_irq_d;
    logic [CAUSE_W-1:0] code_q, code_d;
    logic [XLEN-1:0]    epc_q, epc_d;
    logic [XLEN-1:0]    val_q, val_d;
    logic [XLEN-1:0]    snap_mstatus_q, snap_mstatus_d;
    logic [1:0]         snap_priv_q, snap_priv_d;

    logic               trap_taken_q, trap_taken_d;
    logic               pc_ret_taken_q, pc_ret_taken_d;
    logic               csr_we_q, csr_we_d;
    logic [XLEN-1:0]    pc_trap_next_q, pc_trap_next_d;
    logic [XLEN-1:0]    pc_ret_q, pc_ret_d;
    logic [XLEN-1:0]    mepc_next_q, mepc_next_d;
    logic [XLEN-1:0]    mcause_next_q, mcause_next_d;
    logic [XLEN-1:0]    mtval_next_q, mtval_next_d;
    logic [XLEN-1:0]    mstatus_next_q, mstatus_next_d;
    logic [1:0]         priv_lvl_next_q, priv_lvl_next_d;

    logic [NUM_IRQ-1:0] irq_masked;
    logic               gie;
    logic               irq_hit;
    logic [CAUSE_W-1:0] irq_code;
    logic [XLEN-1:0]    tvec_base;
    logic [XLEN-1:0]    tvec_off;
    logic               use_vec;
    logic [XLEN-1:0]    trap_target;

    // Machine-mode interrupts are globally enabled by MIE, or always when running below M.
    assign gie        = bus.mstatus_current[MIE_BIT] | (bus.priv_lvl != 2'b11);
    assign irq_masked = bus.irq_pending & bus.irq_enable;
    assign irq_hit    = (|irq_masked) & gie;

    // Ascending scan so the highest pending index is the one left standing.
    always_comb begin
        irq_code = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (irq_masked[i]) begin
                irq_code = CAUSE_W'(i);
            end
        end
    end

    assign tvec_base   = {bus.mtvec[XLEN-1:2], 2'b00};
    assign tvec_off    = {{(XLEN-CAUSE_W-2){1'b0}}, code_q, 2'b00};
    assign use_vec     = VECTORED_EN && (bus.mtvec[1:0] == 2'b01) && is_irq_q;
    assign trap_target = use_vec ? (tvec_base + tvec_off) : tvec_base;

    always_comb begin
        state_d         = state_q;
        is_irq_d        = is_irq_q;
        code_d          = code_q;
        epc_d           = epc_q;
        val_d           = val_q;
        snap_mstatus_d  = snap_mstatus_q;
        snap_priv_d     = snap_priv_q;
        trap_taken_d    = 1'b0;
        pc_ret_taken_d  = 1'b0;
        csr_we_d        = 1'b0;
        pc_trap_next_d  = pc_trap_next_q;
        pc_ret_d        = pc_ret_q;
        mepc_next_d     = mepc_next_q;
        mcause_next_d   = mcause_next_q;
        mtval_next_d    = mtval_next_q;
        mstatus_next_d  = mstatus_next_q;
        priv_lvl_next_d = priv_lvl_next_q;

        case (state_q)
            IDLE: begin
                if (bus.exc_en || irq_hit) begin
                    state_d        = FLUSH;
                    is_irq_d       = ~bus.exc_en;
                    code_d         = bus.exc_en ? bus.exc_code : irq_code;
                    epc_d          = bus.pc_addr;
                    val_d          = bus.exc_en ? bus.exc_val : '0;
                    snap_mstatus_d = bus.mstatus_current;
                    snap_priv_d    = bus.priv_lvl;
                end else if (bus.mret) begin
                    pc_ret_taken_d           = 1'b1;
                    csr_we_d                 = 1'b1;
                    pc_ret_d                 = bus.mepc_current;
                    priv_lvl_next_d          = bus.mstatus_current[12:11];
                    mstatus_next_d           = bus.mstatus_current;
                    mstatus_next_d[MIE_BIT]  = bus.mstatus_current[MPIE_BIT];
                    mstatus_next_d[MPIE_BIT] = 1'b1;
                    mstatus_next_d[12:11]    = 2'b00;
                end
            end
            FLUSH: begin
                if (bus.flush_ack) begin
                    state_d                  = IDLE;
                    trap_taken_d             = 1'b1;
                    csr_we_d                 = 1'b1;
                    pc_trap_next_d           = trap_target;
                    mepc_next_d              = epc_q;
                    mcause_next_d            = {is_irq_q, {(XLEN-1-CAUSE_W){1'b0}}, code_q};
                    mtval_next_d             = val_q;
                    mstatus_next_d           = snap_mstatus_q;
                    mstatus_next_d[MPIE_BIT] = snap_mstatus_q[MIE_BIT];
                    mstatus_next_d[MIE_BIT]  = 1'b0;
                    mstatus_next_d[12:11]    = snap_priv_q;
                    priv_lvl_next_d          = 2'b11;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            is_irq_q        <= 1'b0;
            code_q          <= '0;
            epc_q           <= '0;
            val_q           <= '0;
            snap_mstatus_q  <= '0;
            snap_priv_q     <= 2'b00;
            trap_taken_q    <= 1'b0;
            pc_ret_taken_q  <= 1'b0;
            csr_we_q        <= 1'b0;
            pc_trap_next_q  <= '0;
            pc_ret_q        <= '0;
            mepc_next_q     <= '0;
            mcause_next_q   <= '0;
            mtval_next_q    <= '0;
            mstatus_next_q  <= '0;
            priv_lvl_next_q <= 2'b11;
        end else begin
            state_q         <= state_d;
            is_irq_q        <= is_irq_d;
            code_q          <= code_d;
            epc_q           <= epc_d;
            val_q           <= val_d;
            snap_mstatus_q  <= snap_mstatus_d;
            snap_priv_q     <= snap_priv_d;
            trap_taken_q    <= trap_taken_d;
            pc_ret_taken_q  <= pc_ret_taken_d;
            csr_we_q        <= csr_we_d;
            pc_trap_next_q  <= pc_trap_next_d;
            pc_ret_q        <= pc_ret_d;
            mepc_next_q     <= mepc_next_d;
            mcause_next_q   <= mcause_next_d;
            mtval_next_q    <= mtval_next_d;
            mstatus_next_q  <= mstatus_next_d;
            priv_lvl_next_q <= priv_lvl_next_d;
        end
    end

    assign bus.busy          = (state_q == FLUSH);
    assign bus.trap_taken    = trap_taken_q;
    assign bus.pc_trap_next  = pc_trap_next_q;
    assign bus.pc_ret_taken  = pc_ret_taken_q;
    assign bus.pc_ret        = pc_ret_q;
    assign bus.csr_we        = csr_we_q;
    assign bus.mepc_next     = mepc_next_q;
    assign bus.mcause_next   = mcause_next_q;
    assign bus.mtval_next    = mtval_next_q;
    assign bus.mstatus_next  = mstatus_next_q;
    assign bus.priv_lvl_next = priv_lvl_next_q;

endmodule

// File: tb/tb_trap_unit.sv
// Directed and randomized checks of trap_unit against a rule-level reference model.
module tb_trap_unit;
    localparam int XLEN    = 64;
    localparam int NUM_IRQ = 16;
    localparam int CAUSE_W = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    trap_unit_if #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ), .CAUSE_W(CAUSE_W)) bus ();

    trap_unit #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ), .CAUSE_W(CAUSE_W), .VECTORED_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    // Expected outcome of the currently driven stimulus: 0 nothing, 1 trap, 2 mret.
    int              exp_kind;
    logic [XLEN-1:0] exp_pc;
    logic [XLEN-1:0] exp_epc;
    logic [XLEN-1:0] exp_cause;
    logic [XLEN-1:0] exp_tval;
    logic [XLEN-1:0] exp_mstatus;
    logic [1:0]      exp_priv;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic predict();
        logic [NUM_IRQ-1:0] m;
        bit                 gie;
        bit                 irq;
        bit                 is_irq;
        int                 code;
        logic [XLEN-1:0]    base;
        logic [XLEN-1:0]    ms;
        m    = bus.irq_pending & bus.irq_enable;
        gie  = (bus.mstatus_current[3] == 1'b1) || (bus.priv_lvl != 2'd3);
        irq  = (m != 0) && gie;
        code = 0;
        ms   = bus.mstatus_current;
        if (bus.exc_en || irq) begin
            exp_kind = 1;
            is_irq   = !bus.exc_en;
            if (bus.exc_en) begin
                code     = int'(bus.exc_code);
                exp_tval = bus.exc_val;
            end else begin
                for (int i = NUM_IRQ - 1; i >= 0; i--) begin
                    if (m[i]) begin
                        code = i;
                        break;
                    end
                end
                exp_tval = 0;
            end
            exp_cause = (is_irq ? 64'h8000_0000_0000_0000 : 64'h0) + 64'(code);
            exp_epc   = bus.pc_addr;
            base      = bus.mtvec - 64'(bus.mtvec % 4);
            exp_pc    = (is_irq && (bus.mtvec % 4 == 1)) ? base + 64'(4 * code) : base;
            ms[7]     = bus.mstatus_current[3];
            ms[3]     = 1'b0;
            ms[12:11] = bus.priv_lvl;
            exp_mstatus = ms;
            exp_priv  = 2'd3;
        end else if (bus.mret) begin
            exp_kind  = 2;
            exp_pc    = bus.mepc_current;
            exp_priv  = bus.mstatus_current[12:11];
            ms[3]     = bus.mstatus_current[7];
            ms[7]     = 1'b1;
            ms[12:11] = 2'd0;
            exp_mstatus = ms;
        end else begin
            exp_kind = 0;
        end
    endtask

    task automatic quiet();
        bus.exc_en      = 1'b0;
        bus.mret        = 1'b0;
        bus.irq_pending = '0;
        bus.flush_ack   = 1'b0;
    endtask

    task automatic set_all(input bit exc, input logic [CAUSE_W-1:0] code, input logic [XLEN-1:0] val,
                           input logic [NUM_IRQ-1:0] pend, input logic [NUM_IRQ-1:0] en, input bit mr,
                           input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tvec,
                           input logic [XLEN-1:0] mepc, input logic [1:0] priv, input logic [XLEN-1:0] ms);
        bus.exc_en = exc; bus.exc_code = code; bus.exc_val = val;
        bus.irq_pending = pend; bus.irq_enable = en; bus.mret = mr;
        bus.pc_addr = pc; bus.mtvec = tvec; bus.mepc_current = mepc;
        bus.priv_lvl = priv; bus.mstatus_current = ms; bus.flush_ack = 1'b0;
    endtask

    // Runs one transaction from the currently driven inputs (called #1 after an edge).
    task automatic run_txn(input int ack_dly);
        predict();
        n_txn++;
        @(posedge clk); #1;
        if (exp_kind == 1) begin
            check("accept_busy", 64'(bus.busy), 64'd1);
            check("accept_no_ret", 64'(bus.pc_ret_taken), 64'd0);
            check("accept_no_trap", 64'(bus.trap_taken), 64'd0);
            // Causes change or vanish while draining; only the latched cause may commit.
            bus.exc_en = 1'($urandom_range(0, 1)); bus.exc_code = CAUSE_W'($urandom);
            bus.exc_val = {$urandom, $urandom}; bus.pc_addr = {$urandom, $urandom};
            bus.irq_pending = NUM_IRQ'($urandom); bus.mret = 1'($urandom_range(0, 1));
            bus.mstatus_current = {$urandom, $urandom}; bus.priv_lvl = 2'($urandom);
            for (int k = 0; k < ack_dly; k++) begin
                @(posedge clk); #1;
                check("wait_busy", 64'(bus.busy), 64'd1);
                check("wait_no_trap", 64'({bus.trap_taken, bus.csr_we, bus.pc_ret_taken}), 64'd0);
            end
            bus.flush_ack = 1'b1;
            @(posedge clk); #1;
            check("trap_taken", 64'(bus.trap_taken), 64'd1);
            check("trap_csr_we", 64'(bus.csr_we), 64'd1);
            check("trap_busy_clear", 64'(bus.busy), 64'd0);
            check("trap_no_ret", 64'(bus.pc_ret_taken), 64'd0);
            check("pc_trap_next", bus.pc_trap_next, exp_pc);
            check("mepc_next", bus.mepc_next, exp_epc);
            check("mcause_next", bus.mcause_next, exp_cause);
            check("mtval_next", bus.mtval_next, exp_tval);
            check("trap_mstatus_next", bus.mstatus_next, exp_mstatus);
            check("trap_priv_next", 64'(bus.priv_lvl_next), 64'(exp_priv));
            $display("txn %0d: trap cause=%h pc=%h ack_dly=%0d", n_txn, exp_cause, exp_pc, ack_dly);
        end else if (exp_kind == 2) begin
            check("ret_taken", 64'(bus.pc_ret_taken), 64'd1);
            check("ret_csr_we", 64'(bus.csr_we), 64'd1);
            check("ret_no_trap", 64'(bus.trap_taken), 64'd0);
            check("ret_busy", 64'(bus.busy), 64'd0);
            check("pc_ret", bus.pc_ret, exp_pc);
            check("ret_priv_next", 64'(bus.priv_lvl_next), 64'(exp_priv));
            check("ret_mstatus_next", bus.mstatus_next, exp_mstatus);
            $display("txn %0d: mret pc_ret=%h priv=%0d", n_txn, exp_pc, exp_priv);
        end else begin
            check("idle_busy", 64'(bus.busy), 64'd0);
            check("idle_no_pulse", 64'({bus.trap_taken, bus.csr_we, bus.pc_ret_taken}), 64'd0);
            $display("txn %0d: no event", n_txn);
        end
        quiet();
    endtask

    initial begin
        rst_n = 1'b0;
        set_all(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 0);
        #12;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_pulses", 64'({bus.trap_taken, bus.csr_we, bus.pc_ret_taken}), 64'd0);
        check("rst_pc_trap", bus.pc_trap_next, 64'd0);
        check("rst_mcause", bus.mcause_next, 64'd0);
        check("rst_mstatus", bus.mstatus_next, 64'd0);
        check("rst_priv", 64'(bus.priv_lvl_next), 64'd3);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Synchronous exception, ack two cycles after acceptance.
        set_all(1, 6'd2, 64'hDEAD, 0, 0, 0, 64'h100, 64'h800, 0, 2'd0, 64'h8);
        run_txn(1);
        // Vectored interrupt, highest index wins; then direct mode.
        set_all(0, 0, 0, 16'h0088, 16'h0088, 0, 64'h200, 64'h801, 0, 2'd3, 64'h8);
        run_txn(0);
        set_all(0, 0, 0, 16'h0088, 16'h0088, 0, 64'h200, 64'h800, 0, 2'd3, 64'h8);
        run_txn(0);
        // Masked in M-mode with MIE=0, taken from U-mode.
        set_all(0, 0, 0, 16'h0010, 16'h0010, 0, 64'h300, 64'h801, 0, 2'd3, 64'h0);
        run_txn(0);
        run_txn(0);
        set_all(0, 0, 0, 16'h0010, 16'h0010, 0, 64'h300, 64'h801, 0, 2'd0, 64'h0);
        run_txn(0);
        // All three sources together: exception wins, mret dropped.
        set_all(1, 6'd5, 64'h55, 16'h8000, 16'h8000, 1, 64'h400, 64'h801, 64'h104, 2'd3, 64'h8);
        run_txn(0);
        // Plain mret.
        set_all(0, 0, 0, 0, 0, 1, 64'h500, 64'h800, 64'h104, 2'd3, 64'h80);
        run_txn(0);
        // Long drain.
        set_all(1, 6'd11, 64'h77, 0, 0, 0, 64'h600, 64'h800, 0, 2'd3, 64'h8);
        run_txn(10);

        // Reset while draining aborts without any pulse.
        set_all(1, 6'd3, 64'h1, 0, 0, 0, 64'h700, 64'h800, 0, 2'd3, 64'h8);
        @(posedge clk); #1;
        check("mid_rst_busy_before", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        bus.flush_ack = 1'b1;
        #1;
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_pulses", 64'({bus.trap_taken, bus.csr_we, bus.pc_ret_taken}), 64'd0);
        check("mid_rst_priv", 64'(bus.priv_lvl_next), 64'd3);
        @(posedge clk); #1;
        quiet();
        bus.flush_ack = 1'b1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_no_trap", 64'({bus.trap_taken, bus.busy}), 64'd0);
        quiet();
        $display("txn %0d: reset during drain", ++n_txn);

        // Back-to-back random transactions.
        for (int t = 0; t < 60; t++) begin
            set_all(($urandom_range(0, 3) == 0), CAUSE_W'($urandom), {$urandom, $urandom},
                    NUM_IRQ'($urandom), NUM_IRQ'($urandom), 1'($urandom_range(0, 1)),
                    {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                    2'($urandom), {$urandom, $urandom});
            run_txn($urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
